tl45_wb_bram: RTL

TL45_WB_BRAM -- requirements
Module: tl45_wb_bram

---
 rtl/tl45_wb_pkg.sv | 16 +
 rtl/tl45_bram_sp.sv | 28 ++
 rtl/tl45_wb_bram.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tl45_wb_pkg.sv
// Shared types and bus constants for the TL45 Wishbone block RAM.
package tl45_wb_pkg;

    localparam int WB_ADDR_W  = 30;
    localparam int WB_DATA_W  = 32;
    localparam int WB_SEL_W   = 4;
    localparam int WAIT_CNT_W = 4;

    // Bus-side transaction FSM: accept in IDLE, optional wait, one response cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

endpackage

// File: rtl/tl45_bram_sp.sv
// Single-port block RAM: synchronous read, per-byte write enable, no reset
// so that it maps onto FPGA block RAM primitives.
module tl45_bram_sp
    import tl45_wb_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = WB_DATA_W
) (
    input  logic              i_clk,
    input  logic [AW-1:0]     i_addr,
    input  logic [DW/8-1:0]   i_we,
    input  logic [DW-1:0]     i_wdata,
    output logic [DW-1:0]     o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Byte-lane writes and registered read on the same port.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < DW/8; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/tl45_wb_bram.sv
// Wishbone (pipelined, single outstanding) slave wrapping a block RAM.
// Writes commit on the accepting edge; the response (ack on hit, err on
// decode miss) appears WAIT_CYCLES+1 cycles after accept. The RAM address
// follows the bus while idle and the latched index while busy, so the
// registered read data is ready in the response cycle.
module tl45_wb_bram
    import tl45_wb_pkg::*;
#(
    parameter int                   ADDR_WIDTH  = 12,
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 30'h0,
    parameter int                   WAIT_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [WB_ADDR_W-1:0]  i_wb_addr,
    input  logic [WB_DATA_W-1:0]  i_wb_data,
    input  logic [WB_SEL_W-1:0]   i_wb_sel,
    output logic                  o_wb_ack,
    output logic                  o_wb_stall,
    output logic                  o_wb_err,
    output logic [WB_DATA_W-1:0]  o_wb_data
);

    // Counter value on entering WAIT; exit happens when it reaches zero.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    wb_state_t               r_state;
    wb_state_t               w_next_state;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [ADDR_WIDTH-1:0]   r_index;
    logic                    r_we;
    logic [WB_DATA_W-1:0]    r_data;
    logic [WB_SEL_W-1:0]     r_sel;
    logic                    r_hit;

    logic                    w_accept;
    logic                    w_hit;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [WB_SEL_W-1:0]     w_ram_we;
    logic [WB_DATA_W-1:0]    w_ram_q;
    logic                    w_unused_latched;

    // Handshake: a request transfers on a rising edge when cyc & stb are
    // high and stall is low; stall is low only in IDLE, so at most one
    // request is outstanding and ack/err closes it one cycle wide.
    assign w_accept = i_wb_cyc && i_wb_stb && (r_state == ST_IDLE);
    assign w_hit    = (i_wb_addr[WB_ADDR_W-1:ADDR_WIDTH] == BASE_ADDR[WB_ADDR_W-1:ADDR_WIDTH]);

    // Write data and lane select are consumed at accept; the latched copies
    // are kept only as a record of the accepted request.
    assign w_unused_latched = ^{r_data, r_sel};

    assign w_ram_addr = (r_state == ST_IDLE) ? i_wb_addr[ADDR_WIDTH-1:0] : r_index;
    assign w_ram_we   = {WB_SEL_W{w_accept && w_hit && i_wb_we && !i_reset}} & i_wb_sel;

    tl45_bram_sp #(
        .AW (ADDR_WIDTH),
        .DW (WB_DATA_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (i_wb_data),
        .o_rdata (w_ram_q)
    );

    // State register, wait counter and accepted-request latches.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_index    <= '0;
            r_we       <= 1'b0;
            r_data     <= '0;
            r_sel      <= '0;
            r_hit      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_index    <= i_wb_addr[ADDR_WIDTH-1:0];
                r_we       <= i_wb_we;
                r_data     <= i_wb_data;
                r_sel      <= i_wb_sel;
                r_hit      <= w_hit;
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
        end
    end

    // Next-state: dropping cyc while busy abandons the transaction.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt == '0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from state; read data is zero outside a read-hit response.
    always_comb begin
        o_wb_stall = (r_state != ST_IDLE);
        o_wb_ack   = (r_state == ST_RESP) && r_hit && i_wb_cyc;
        o_wb_err   = (r_state == ST_RESP) && !r_hit && i_wb_cyc;
        o_wb_data  = '0;
        if ((r_state == ST_RESP) && r_hit && !r_we) begin
            o_wb_data = w_ram_q;
        end
    end

endmodule
